// File: rtl/vcb_udm_chain.sv
// Cascaded modulo-MOD up/down counter, DIGITS stages of WIDTH bits, with load and terminal count.
// Optional synchronous set input s is built only when VCB_SET_EN is defined.
module vcb_udm_chain #(
  parameter int WIDTH  = 4,
  parameter int MOD    = 10,
  parameter int DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    ce,
  input  logic                    up,
  input  logic                    load,
  input  logic [DIGITS*WIDTH-1:0] din,
`ifdef VCB_SET_EN
  input  logic                    s,
`endif
  output logic [DIGITS*WIDTH-1:0] Q,
  output logic                    TC,
  output logic                    CEO
);

  localparam logic [WIDTH-1:0] DMAX = WIDTH'(MOD - 1);

  logic [WIDTH-1:0]  dig     [DIGITS];
  logic [WIDTH-1:0]  dig_nxt [DIGITS];
  logic [DIGITS-1:0] term;
  logic [DIGITS-1:0] step;

  // term[i] doubles as the wrap condition: MOD-1 when counting up, 0 when counting down.
  always_comb begin
    logic run;
    run  = ce;
    term = '0;
    step = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      term[i] = up ? (dig[i] == DMAX) : (dig[i] == '0);
      step[i] = run;
      run     = run & term[i];
    end
  end

  assign TC  = &term;
  assign CEO = ce & TC;

  always_comb begin
    logic [WIDTH-1:0] ld;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      ld         = din[i*WIDTH +: WIDTH];
      dig_nxt[i] = dig[i];
`ifdef VCB_SET_EN
      if (s) begin
        dig_nxt[i] = DMAX;
      end else
`endif
      if (load) begin
        dig_nxt[i] = (ld > DMAX) ? DMAX : ld;
      end else if (step[i]) begin
        if (up) dig_nxt[i] = term[i] ? '0   : dig[i] + WIDTH'(1);
        else    dig_nxt[i] = term[i] ? DMAX : dig[i] - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (clr) dig[i] <= '0;
      else     dig[i] <= dig_nxt[i];
    end
  end

  always_comb begin
    Q = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      Q[i*WIDTH +: WIDTH] = dig[i];
    end
  end

endmodule

// File: tb/tb_vcb_udm_chain.sv
// Scoreboard bench for vcb_udm_chain (WIDTH=4, MOD=10, DIGITS=2); decimal reference model.
module tb_vcb_udm_chain;

  logic       clk = 1'b0;
  logic       clr = 1'b0, ce = 1'b0, up = 1'b1, load = 1'b0, s = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] Q;
  logic       TC, CEO;

  int          nvec  = 0;
  int          nfail = 0;
  int          m     = 0;
  logic [7:0]  sb_q [$];
  logic [7:0]  exp_q;

  vcb_udm_chain #(.WIDTH(4), .MOD(10), .DIGITS(2)) dut (
    .clk(clk), .clr(clr), .ce(ce), .up(up), .load(load), .din(din),
`ifdef VCB_SET_EN
    .s(s),
`endif
    .Q(Q), .TC(TC), .CEO(CEO)
  );

  always #10 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached, nvec=%0d", nvec);
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic logic exp_tc();
    return up ? (m == 99) : (m == 0);
  endfunction

  // Drive one cycle of inputs at the falling edge and queue the expected Q after the next rising edge.
  task automatic drive(input logic c, input logic e, input logic u, input logic l,
                       input logic [7:0] d, input logic st);
    int hi, lo;
    @(negedge clk);
    clr = c; ce = e; up = u; load = l; din = d; s = st;
    hi = (d[7:4] > 9) ? 9 : int'(d[7:4]);
    lo = (d[3:0] > 9) ? 9 : int'(d[3:0]);
    if (c) m = 0;
`ifdef VCB_SET_EN
    else if (st) m = 99;
`endif
    else if (l) m = hi * 10 + lo;
    else if (e) m = u ? (m + 1) % 100 : (m + 99) % 100;
    sb_q.push_back(to_bcd(m));
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
    exp_q = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 0, 8'h00, 0); settle();
    nvec++; if (Q !== exp_q) begin nfail++; $display("FAIL reset_q: got %h want %h", Q, exp_q); end
    nvec++; if (TC !== 1'b0) begin nfail++; $display("FAIL reset_tc_up: got %b want 0", TC); end
    up = 1'b0; #1;
    nvec++; if (TC !== 1'b1) begin nfail++; $display("FAIL reset_tc_dn: got %b want 1", TC); end
    nvec++; if (CEO !== 1'b1) begin nfail++; $display("FAIL reset_ceo_dn: got %b want 1", CEO); end
    ce = 1'b0; #1;
    nvec++; if (CEO !== 1'b0) begin nfail++; $display("FAIL reset_ceo_ce0: got %b want 0", CEO); end
  endtask

  task automatic test_up_wrap();
    drive(1, 0, 1, 0, 8'h00, 0); settle();
    for (int i = 0; i < 99; i++) begin
      drive(0, 1, 1, 0, 8'h00, 0); settle();
      nvec++; if (Q !== exp_q) begin nfail++; $display("FAIL up_q[%0d]: got %h want %h", i, Q, exp_q); end
    end
    nvec++; if (Q !== 8'h99) begin nfail++; $display("FAIL up_at99: got %h want 99", Q); end
    nvec++; if (TC !== 1'b1 || CEO !== 1'b1) begin nfail++; $display("FAIL up_tc_ceo: got %b%b want 11", TC, CEO); end
    drive(0, 1, 1, 0, 8'h00, 0); settle();
    nvec++; if (Q !== 8'h00 || TC !== 1'b0) begin nfail++; $display("FAIL up_wrap: got %h/%b want 00/0", Q, TC); end
  endtask

  task automatic test_down_wrap();
    @(negedge clk); up = 1'b0; ce = 1'b0; #1;
    nvec++; if (TC !== exp_tc()) begin nfail++; $display("FAIL dn_tc_imm: got %b want %b", TC, exp_tc()); end
    for (int i = 0; i < 11; i++) begin
      drive(0, 1, 0, 0, 8'h00, 0); settle();
      nvec++; if (Q !== exp_q) begin nfail++; $display("FAIL dn_q[%0d]: got %h want %h", i, Q, exp_q); end
      if (i == 0) begin
        nvec++; if (Q !== 8'h99) begin nfail++; $display("FAIL dn_wrap: got %h want 99", Q); end
      end
    end
    nvec++; if (Q !== 8'h89) begin nfail++; $display("FAIL dn_end: got %h want 89", Q); end
  endtask

  task automatic test_gated_ce();
    drive(1, 0, 1, 0, 8'h00, 0); settle();
    for (int i = 0; i < 20; i++) begin
      drive(0, (i % 2 == 0), 1, 0, 8'h00, 0); settle();
      nvec++; if (Q !== exp_q) begin nfail++; $display("FAIL gate_q[%0d]: got %h want %h", i, Q, exp_q); end
    end
    nvec++; if (Q !== 8'h10) begin nfail++; $display("FAIL gate_end: got %h want 10", Q); end
  endtask

  task automatic test_load();
    drive(0, 1, 1, 1, 8'h3F, 0); settle();
    nvec++; if (Q !== exp_q || Q !== 8'h39) begin nfail++; $display("FAIL load_sat: got %h want %h", Q, exp_q); end
    drive(0, 1, 1, 1, 8'h57, 0); settle();
    nvec++; if (Q !== exp_q || Q !== 8'h57) begin nfail++; $display("FAIL load_57: got %h want %h", Q, exp_q); end
    drive(0, 0, 0, 1, 8'hA2, 0); settle();
    nvec++; if (Q !== exp_q) begin nfail++; $display("FAIL load_hi_sat: got %h want %h", Q, exp_q); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 8'h00, 0); settle();
    end
    drive(1, 1, 1, 1, 8'h57, 0); settle();
    nvec++; if (Q !== exp_q || Q !== 8'h00) begin nfail++; $display("FAIL clr_mid: got %h want %h", Q, exp_q); end
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 8'h00, 0); settle();
      nvec++; if (Q !== exp_q) begin nfail++; $display("FAIL clr_hold[%0d]: got %h want %h", i, Q, exp_q); end
    end
    drive(0, 1, 1, 0, 8'h00, 0); settle();
    nvec++; if (Q !== exp_q || Q !== 8'h01) begin nfail++; $display("FAIL clr_resume: got %h want %h", Q, exp_q); end
  endtask

`ifdef VCB_SET_EN
  task automatic test_set();
    drive(0, 1, 1, 1, 8'h12, 1); settle();
    nvec++; if (Q !== exp_q || Q !== 8'h99) begin nfail++; $display("FAIL set_q: got %h want %h", Q, exp_q); end
    nvec++; if (TC !== 1'b1) begin nfail++; $display("FAIL set_tc: got %b want 1", TC); end
    drive(1, 1, 1, 0, 8'h00, 1); settle();
    nvec++; if (Q !== exp_q || Q !== 8'h00) begin nfail++; $display("FAIL set_clr: got %h want %h", Q, exp_q); end
  endtask
`endif

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_gated_ce();
    test_load();
    test_reset_mid();
`ifdef VCB_SET_EN
    test_set();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
